// File: rtl/fsc_pkg.sv
// Shared types and helpers for the fabric self-write checker.
package fsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned word_count(input int unsigned len_bytes);
    return (len_bytes + 3) / 4;
  endfunction

endpackage

// File: rtl/fsc_if.sv
// Bitstream word-memory read port; read data is valid the cycle after the request.
interface fsc_if #(
  parameter int ADDR_W = 13
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/fsc_word_sequencer.sv
// Word-load path: fetch each bitstream word, present it to the fabric, strobe it, hold it.
module fsc_word_sequencer
  import fsc_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic            CLK,
  input  logic            reset,
  input  state_e          state,
  input  logic            load_start,
  input  logic [ADDR_W:0] n_words,
  output state_e          seq_next,
  fsc_if.master           mem,
  output logic [31:0]     SelfWriteData,
  output logic            SelfWriteStrobe
);

  localparam int PH_W = cnt_w((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
  localparam logic [PH_W-1:0] SETUP_LD = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LD  = PH_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic [ADDR_W:0] n_q, n_d, idx_q, idx_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [31:0]     data_q, data_d;
  logic            last_word, first_setup;
  state_e          word_end;

  assign last_word   = (idx_q == n_q - 1'b1);
  assign word_end    = last_word ? ST_SETTLE : ST_FETCH;
  // Read data only exists in the first SETUP cycle, so it is forwarded then and registered for the rest.
  assign first_setup = (state == ST_SETUP) && (ph_q == SETUP_LD);

  always_comb begin
    seq_next = state;
    n_d      = n_q;
    idx_d    = idx_q;
    ph_d     = ph_q;
    data_d   = data_q;
    if (load_start) begin
      n_d   = n_words;
      idx_d = '0;
    end
    if (first_setup) data_d = mem.mem_rdata;
    case (state)
      ST_FETCH: begin
        seq_next = ST_SETUP;
        ph_d     = SETUP_LD;
      end
      ST_SETUP: begin
        if (ph_q == '0) seq_next = ST_STROBE;
        else            ph_d     = ph_q - 1'b1;
      end
      ST_STROBE: begin
        if (HOLD_CYC > 0) begin
          seq_next = ST_HOLD;
          ph_d     = HOLD_LD;
        end else begin
          seq_next = word_end;
          idx_d    = idx_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (ph_q == '0) begin
          seq_next = word_end;
          idx_d    = idx_q + 1'b1;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      n_q    <= '0;
      idx_q  <= '0;
      ph_q   <= '0;
      data_q <= '0;
    end else begin
      n_q    <= n_d;
      idx_q  <= idx_d;
      ph_q   <= ph_d;
      data_q <= data_d;
    end
  end

  assign mem.mem_rd_en    = (state == ST_FETCH);
  assign mem.mem_addr     = idx_q[ADDR_W-1:0];
  assign SelfWriteData    = first_setup ? mem.mem_rdata : data_q;
  assign SelfWriteStrobe  = (state == ST_STROBE);

endmodule

// File: rtl/fabric_selfwrite_checker.sv
// Loads a bitstream into the fabric, lets it settle, then compares fabric vs gold result channels.
// Define FSC_ABORT_ON_ERR_EN to end the compare window on the first mismatching cycle.
module fabric_selfwrite_checker
  import fsc_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int CH_W       = 72,
  parameter int ADDR_W     = 13,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int SETTLE_CYC = 100,
  parameter int CMP_CYC    = 100,
  parameter int ERR_W      = 16
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W+1:0]         bs_len,
  fsc_if.master                     mem,
  output logic [31:0]               SelfWriteData,
  output logic                      SelfWriteStrobe,
  output logic                      stim_en,
  input  logic [NUM_CH*CH_W-1:0]    dut_res,
  input  logic [NUM_CH*CH_W-1:0]    gold_res,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [cnt_w(NUM_CH)-1:0]  first_err_ch,
  output logic [cnt_w(CMP_CYC)-1:0] first_err_cyc
);

  localparam int CH_IW = cnt_w(NUM_CH);
  localparam int CYC_W = cnt_w(CMP_CYC);
  localparam int CNT_W = cnt_w((SETTLE_CYC > CMP_CYC) ? SETTLE_CYC : CMP_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CMP_LD    = CNT_W'(CMP_CYC - 1);

  state_e            state_q, state_d, seq_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CH_IW-1:0]  ch_q, ch_d, mm_ch;
  logic [CYC_W-1:0]  cyc_q, cyc_d, win_off;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   n_words;
  logic              start_acc, load_start, mismatch;

  assign n_words    = (ADDR_W+1)'(word_count(32'(bs_len)));
  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign load_start = start_acc && (n_words != '0);
  assign win_off    = CYC_W'(CMP_LD) - CYC_W'(cnt_q);

  // Descending scan leaves the lowest mismatching channel in mm_ch.
  always_comb begin
    mismatch = 1'b0;
    mm_ch    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (dut_res[c*CH_W +: CH_W] != gold_res[c*CH_W +: CH_W]) begin
        mismatch = 1'b1;
        mm_ch    = CH_IW'(c);
      end
    end
  end

  fsc_word_sequencer #(
    .ADDR_W    (ADDR_W),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_seq (
    .CLK             (CLK),
    .reset           (reset),
    .state           (state_q),
    .load_start      (load_start),
    .n_words         (n_words),
    .seq_next        (seq_next),
    .mem             (mem),
    .SelfWriteData   (SelfWriteData),
    .SelfWriteStrobe (SelfWriteStrobe)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ch_d    = ch_q;
    cyc_d   = cyc_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_acc) begin
          state_d = load_start ? ST_FETCH : ST_SETTLE;
          err_d   = '0;
          ch_d    = '0;
          cyc_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_FETCH, ST_SETUP, ST_STROBE, ST_HOLD: state_d = seq_next;
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_COMPARE;
          cnt_d   = CMP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COMPARE: begin
        if (mismatch) begin
          if (err_q == '0) begin
            ch_d  = mm_ch;
            cyc_d = win_off;
          end
          if (err_q != '1) err_d = err_q + 1'b1;
        end
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
`ifdef FSC_ABORT_ON_ERR_EN
        if (mismatch) state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) cnt_d = SETTLE_LD;
    if (state_d == ST_DONE) pass_d = (err_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      ch_q    <= '0;
      cyc_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
    end
  end

  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign stim_en       = (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_ch  = ch_q;
  assign first_err_cyc = cyc_q;

endmodule

// File: tb/tb_fabric_selfwrite_checker.sv
// Directed and randomized bench for fabric_selfwrite_checker against a cycle-timeline reference model.
module tb_fabric_selfwrite_checker;
  localparam int S   = 100;
  localparam int C   = 100;
  localparam int NCH = 3;
  localparam int CHW = 72;
  localparam int EW  = 4;
  localparam int PER = 6;

  logic              CLK, reset, start;
  logic [14:0]       bs_len;
  logic [31:0]       SelfWriteData;
  logic              SelfWriteStrobe, stim_en, busy, done, pass;
  logic [NCH*CHW-1:0] dut_res, gold_res;
  logic [EW-1:0]     err_count;
  logic [1:0]        first_err_ch;
  logic [6:0]        first_err_cyc;

  fsc_if #(.ADDR_W(13)) mif();

  fabric_selfwrite_checker #(.ERR_W(EW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .bs_len(bs_len), .mem(mif),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe), .stim_en(stim_en),
    .dut_res(dut_res), .gold_res(gold_res), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_ch(first_err_ch), .first_err_cyc(first_err_cyc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_model [0:63];
  logic [2:0]  mm_mask [0:C-1];
  int          fixed_bit = -1;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Read data is valid only the cycle after a request; garbage otherwise.
  always @(posedge CLK)
    mif.mem_rdata <= mif.mem_rd_en ? mem_model[mif.mem_addr[5:0]] : $urandom;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [NCH*CHW-1:0] rand_res();
    return (NCH*CHW)'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic logic [NCH*CHW-1:0] flips(input logic [2:0] m);
    logic [NCH*CHW-1:0] f;
    f = '0;
    for (int c = 0; c < NCH; c++)
      if (m[c]) f[c*CHW + ((fixed_bit >= 0) ? fixed_bit : int'($urandom_range(0, CHW-1)))] = 1'b1;
    return f;
  endfunction

  task automatic clear_mask();
    for (int o = 0; o < C; o++) mm_mask[o] = 3'b000;
    fixed_bit = -1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strobe"}, SelfWriteStrobe, 0);
    chk({tag, "_wdata"},  SelfWriteData, 0);
    chk({tag, "_rd_en"},  mif.mem_rd_en, 0);
    chk({tag, "_addr"},   mif.mem_addr, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_pass"},   pass, 0);
    chk({tag, "_stim"},   stim_en, 0);
    chk({tag, "_err"},    err_count, 0);
    chk({tag, "_fch"},    first_err_ch, 0);
    chk({tag, "_fcyc"},   first_err_cyc, 0);
  endtask

  // Starts a run of len bytes at the current cycle and checks the whole timeline against the model.
  task automatic run_case(input int len);
    int n, cnt, f_off, f_ch, win, t_cmp0, t_done, exp_err;
    n = (len + 3) / 4;
    cnt = 0; f_off = -1; f_ch = 0;
    for (int o = 0; o < C; o++) begin
      if (mm_mask[o] != 3'b000) begin
        cnt++;
        if (f_off < 0) begin
          f_off = o;
          for (int c = NCH - 1; c >= 0; c--) if (mm_mask[o][c]) f_ch = c;
        end
      end
    end
    win = C;
`ifdef FSC_ABORT_ON_ERR_EN
    if (f_off >= 0) begin
      win = f_off + 1;
      cnt = 1;
    end
`endif
    exp_err = (cnt > 2**EW - 1) ? 2**EW - 1 : cnt;
    if (f_off < 0) f_off = 0;
    t_cmp0 = 1 + PER * n + S;
    t_done = t_cmp0 + win;

    bs_len = 15'(len);
    start  = 1'b1;
    @(posedge CLK); #1;
    for (int t = 1; t <= t_done + 2; t++) begin
      int off, k, ph;
      bit in_load;
      off = t - t_cmp0;
      gold_res = rand_res();
      if (off >= 0 && off < C) dut_res = gold_res ^ flips(mm_mask[off]);
      else                     dut_res = gold_res ^ flips(3'b111);
      start = (t == 3);
      if (t == 3) bs_len = 15'($urandom_range(0, 40));
      k = (t - 1) / PER;
      ph = (t - 1) % PER;
      in_load = (t <= PER * n);
      chk("rd_en", mif.mem_rd_en, in_load && ph == 0);
      if (in_load && ph == 0) chk("addr", mif.mem_addr, k);
      chk("strobe", SelfWriteStrobe, in_load && ph == 3);
      if (in_load && ph >= 1) chk("wdata", SelfWriteData, mem_model[k]);
      if (n > 0 && t == PER * n + 1) chk("wdata_last", SelfWriteData, mem_model[n-1]);
      chk("busy", busy, t < t_done);
      chk("stim_en", stim_en, t > PER * n && t < t_done);
      chk("done", done, t == t_done);
      if (t == t_done || t == t_done + 2) begin
        chk("pass", pass, exp_err == 0);
        chk("err_count", err_count, exp_err);
        chk("first_err_ch", first_err_ch, f_ch);
        chk("first_err_cyc", first_err_cyc, f_off);
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; bs_len = 15'd12;
    dut_res = '0; gold_res = '0;
    fill_mem();
    clear_mask();
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    reset = 1'b0; start = 1'b0;
    @(posedge CLK); #1;
    check_zero("post_reset");

    // Three words, clean compare.
    run_case(12);

    // Empty bitstream goes straight to settle.
    run_case(0);

    // Channel 2 bit 5 wrong for offsets 10..14.
    clear_mask();
    fixed_bit = 5;
    for (int o = 10; o <= 14; o++) mm_mask[o] = 3'b100;
    run_case(5);

    // Channels 0 and 1 wrong all window: counter saturates.
    clear_mask();
    for (int o = 0; o < C; o++) mm_mask[o] = 3'b011;
    run_case(0);

    // Single mismatch at offset 7.
    clear_mask();
    mm_mask[7] = 3'b010;
    run_case(3);

    // Reset during the second word's first SETUP cycle.
    clear_mask();
    fill_mem();
    bs_len = 15'd12;
    start  = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int t = 1; t < PER + 2; t++) begin
      @(posedge CLK); #1;
    end
    chk("pre_abort_wdata", SelfWriteData, mem_model[1]);
    reset = 1'b1;
    @(posedge CLK); #1;
    check_zero("abort");
    reset = 1'b0;
    @(posedge CLK); #1;
    run_case(12);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      fill_mem();
      clear_mask();
      for (int o = 0; o < C; o++)
        if ($urandom_range(0, 9) == 0) mm_mask[o] = 3'($urandom_range(1, 7));
      run_case(int'($urandom_range(0, 30)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
